mem_ctrl: RTL and testbench

- Sits inside cpu, between the instruction-fetch unit (IF) and the load/store unit (LSU) on one side, and the single byte-wide CPU memory port (mem_a/mem_dout/mem_wr/mem_din) on the other.
- Arbitrates the two requesters onto the port.
- Serialises word, half and byte accesses into per-byte bus cycles and reassembles read bytes little-endian.
- Honours rdy_in stalls and io_buffer_full back-pressure for the I/O region (addr[17:16]==2'b11).

---
 rtl/mem_ctrl_pkg.sv | 31 +++
 rtl/mem_ctrl_arb.sv | 46 ++++
 rtl/mem_ctrl.sv | 166 ++++++++++++++++
 tb/tb_mem_ctrl.sv | 261 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_ctrl_pkg.sv
// Shared encodings for the CPU memory controller: FSM states, requester
// owner codes, access-size codes and the I/O region selector.
package mem_ctrl_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_READ  = 2'd1,
        ST_WRITE = 2'd2
    } state_e;

    typedef enum logic {
        OWN_IF = 1'b0,
        OWN_LS = 1'b1
    } owner_e;

    localparam logic [1:0] SZ_B  = 2'd0;
    localparam logic [1:0] SZ_H  = 2'd1;
    localparam logic [1:0] SZ_W  = 2'd2;
    localparam logic [1:0] IO_HI = 2'b11;

    // Byte count of an access; the unused size code 3 behaves as a word.
    function automatic logic [2:0] size_to_n(input logic [1:0] size);
        case (size)
            SZ_B:    return 3'd1;
            SZ_H:    return 3'd2;
            SZ_W:    return 3'd4;
            default: return 3'd4;
        endcase
    endfunction

endpackage

// File: rtl/mem_ctrl_arb.sv
// Grant logic for the IF / LSU requesters. Fixed LSU priority by default;
// defining MEM_CTRL_RR_EN switches ties to round-robin on a last-owner flag.
module mem_ctrl_arb
    import mem_ctrl_pkg::*;
(
`ifdef MEM_CTRL_RR_EN
    input  logic   clk_in,
    input  logic   rst_in,
`endif
    input  logic   en_i,
    input  logic   if_req_i,
    input  logic   if_done_i,
    input  logic   ls_req_i,
    input  logic   ls_done_i,
    output logic   gnt_o,
    output owner_e owner_o
);

    logic if_elig;
    logic ls_elig;
    logic pick_ls;

    // A requester still holds req during its own done cycle; that must not re-grant it.
    assign if_elig = if_req_i && !if_done_i;
    assign ls_elig = ls_req_i && !ls_done_i;

`ifdef MEM_CTRL_RR_EN
    owner_e last_q;

    assign pick_ls = ls_elig && (!if_elig || (last_q == OWN_IF));

    always_ff @(posedge clk_in) begin
        if (!rst_in) begin
            last_q <= OWN_IF;
        end else if (gnt_o) begin
            last_q <= owner_o;
        end
    end
`else
    assign pick_ls = ls_elig;
`endif

    assign gnt_o   = en_i && (if_elig || ls_elig);
    assign owner_o = pick_ls ? OWN_LS : OWN_IF;

endmodule

// File: rtl/mem_ctrl.sv
// Byte-serialising memory controller between IF/LSU and the 8-bit CPU port.
// Optional round-robin arbitration via MEM_CTRL_RR_EN (see mem_ctrl_arb).
module mem_ctrl #(
    parameter int         ADDR_W = 32,
    parameter logic [1:0] IO_HI  = mem_ctrl_pkg::IO_HI
) (
    input  logic              clk_in,
    input  logic              rst_in,
    input  logic              rdy_in,
    input  logic [7:0]        mem_din,
    output logic [7:0]        mem_dout,
    output logic [ADDR_W-1:0] mem_a,
    output logic              mem_wr,
    input  logic              io_buffer_full,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    output logic              if_done,
    output logic [31:0]       if_data,
    input  logic              ls_req,
    input  logic              ls_wr,
    input  logic [1:0]        ls_size,
    input  logic [ADDR_W-1:0] ls_addr,
    input  logic [31:0]       ls_wdata,
    output logic              ls_done,
    output logic [31:0]       ls_rdata
);
    import mem_ctrl_pkg::*;

    state_e            state_q;
    owner_e            owner_q;
    logic [ADDR_W-1:0] addr_q;
    logic [31:0]       wdata_q;
    logic [2:0]        n_q, iss_q, cap_q;
    logic              a_vld_q, d_vld_q;
    logic [31:0]       data_q;
    logic [ADDR_W-1:0] mem_a_q;
    logic [7:0]        mem_dout_q;
    logic              mem_wr_q, if_done_q, ls_done_q;
    logic [31:0]       if_data_q, ls_rdata_q;

    logic              gnt, gnt_ls, req_wr, idle, io_hold, rd_issue, wr_issue;
    owner_e            gnt_owner;
    logic [ADDR_W-1:0] req_addr, cur_addr, byte_addr;
    logic [31:0]       cur_wdata, rdata_d;
    logic [2:0]        req_n, cur_n, cur_iss;

    mem_ctrl_arb u_arb (
`ifdef MEM_CTRL_RR_EN
        .clk_in    (clk_in),
        .rst_in    (rst_in),
`endif
        .en_i      ((state_q == ST_IDLE) && rdy_in),
        .if_req_i  (if_req),
        .if_done_i (if_done_q),
        .ls_req_i  (ls_req),
        .ls_done_i (ls_done_q),
        .gnt_o     (gnt),
        .owner_o   (gnt_owner)
    );

    // In IDLE the first byte is issued on the grant edge, so the "current"
    // request view comes straight from the requester rather than the latches.
    always_comb begin
        // NOTE: every always_comb output gets a value on every path, else a latch is inferred.
        gnt_ls    = gnt && (gnt_owner == OWN_LS);
        req_addr  = gnt_ls ? ls_addr : if_addr;
        req_wr    = gnt_ls && ls_wr;
        req_n     = gnt_ls ? size_to_n(ls_size) : 3'd4;
        idle      = (state_q == ST_IDLE);
        cur_addr  = idle ? req_addr : addr_q;
        cur_wdata = idle ? ls_wdata : wdata_q;
        cur_n     = idle ? req_n : n_q;
        cur_iss   = idle ? 3'd0 : iss_q;
        byte_addr = cur_addr + ADDR_W'(cur_iss);
        io_hold   = (byte_addr[17:16] == IO_HI) && io_buffer_full;
        rd_issue  = (idle ? (gnt && !req_wr) : (state_q == ST_READ)) && (cur_iss < cur_n);
        wr_issue  = (idle ? (gnt && req_wr) : (state_q == ST_WRITE)) && (cur_iss < cur_n);
        rdata_d   = data_q;
        rdata_d[{cap_q[1:0], 3'b000} +: 8] = mem_din;
    end

    always_ff @(posedge clk_in) begin
        // NOTE: sequential state uses non-blocking assignments only, so every register samples pre-edge values.
        if (!rst_in) begin
            state_q    <= ST_IDLE;
            owner_q    <= OWN_IF;
            addr_q     <= '0;
            wdata_q    <= '0;
            n_q        <= '0;
            iss_q      <= '0;
            cap_q      <= '0;
            a_vld_q    <= 1'b0;
            d_vld_q    <= 1'b0;
            data_q     <= '0;
            mem_a_q    <= '0;
            mem_dout_q <= '0;
            mem_wr_q   <= 1'b0;
            if_done_q  <= 1'b0;
            ls_done_q  <= 1'b0;
            if_data_q  <= '0;
            ls_rdata_q <= '0;
        end else begin
            if_done_q <= 1'b0;
            ls_done_q <= 1'b0;
            mem_wr_q  <= 1'b0;
            mem_a_q   <= '0;
            a_vld_q   <= 1'b0;
            if (!rdy_in) begin
                // Bus lost: any read byte in flight is unreliable, so rewind issue to capture.
                d_vld_q <= 1'b0;
                if (state_q == ST_READ) iss_q <= cap_q;
            end else begin
                d_vld_q <= a_vld_q;
                if (idle && gnt) begin
                    state_q <= req_wr ? ST_WRITE : ST_READ;
                    owner_q <= gnt_owner;
                    addr_q  <= req_addr;
                    wdata_q <= ls_wdata;
                    n_q     <= req_n;
                    iss_q   <= 3'd0;
                    cap_q   <= 3'd0;
                    data_q  <= '0;
                end
                if (rd_issue) begin
                    mem_a_q <= byte_addr;
                    a_vld_q <= 1'b1;
                    iss_q   <= cur_iss + 3'd1;
                end
                if (wr_issue && !io_hold) begin
                    mem_a_q    <= byte_addr;
                    mem_dout_q <= cur_wdata[{cur_iss[1:0], 3'b000} +: 8];
                    mem_wr_q   <= 1'b1;
                    iss_q      <= cur_iss + 3'd1;
                end
                if ((state_q == ST_WRITE) && (iss_q == n_q)) begin
                    state_q <= ST_IDLE;
                    if (owner_q == OWN_LS) ls_done_q <= 1'b1;
                    else                   if_done_q <= 1'b1;
                end
                if ((state_q == ST_READ) && d_vld_q) begin
                    data_q <= rdata_d;
                    cap_q  <= cap_q + 3'd1;
                    if ((cap_q + 3'd1) == n_q) begin
                        state_q <= ST_IDLE;
                        if (owner_q == OWN_LS) begin
                            ls_done_q  <= 1'b1;
                            ls_rdata_q <= rdata_d;
                        end else begin
                            if_done_q <= 1'b1;
                            if_data_q <= rdata_d;
                        end
                    end
                end
            end
        end
    end

    assign mem_a    = mem_a_q;
    assign mem_dout = mem_dout_q;
    assign mem_wr   = mem_wr_q;
    assign if_done  = if_done_q;
    assign if_data  = if_data_q;
    assign ls_done  = ls_done_q;
    assign ls_rdata = ls_rdata_q;

endmodule

// File: tb/tb_mem_ctrl.sv
// Self-checking bench for mem_ctrl: table of single LSU accesses plus
// directed sequences for fetch, arbitration ties, I/O back-pressure, stalls and reset.
module tb_mem_ctrl;

    logic        clk_in = 1'b0;
    logic        rst_in, rdy_in, io_buffer_full;
    logic [7:0]  mem_din, mem_dout;
    logic [31:0] mem_a;
    logic        mem_wr;
    logic        if_req, if_done;
    logic [31:0] if_addr, if_data;
    logic        ls_req, ls_wr, ls_done;
    logic [1:0]  ls_size;
    logic [31:0] ls_addr, ls_wdata, ls_rdata;

    int n_checks = 0;
    int n_errors = 0;
    int wr_cnt   = 0;

    typedef struct {
        logic        wr;
        logic [1:0]  size;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] exp_rdata;
        int          exp_lat;
        int          exp_nwr;
    } vec_t;

    vec_t vecs [10];

    always #5 clk_in = ~clk_in;

    mem_ctrl dut (
        .clk_in         (clk_in),
        .rst_in         (rst_in),
        .rdy_in         (rdy_in),
        .mem_din        (mem_din),
        .mem_dout       (mem_dout),
        .mem_a          (mem_a),
        .mem_wr         (mem_wr),
        .io_buffer_full (io_buffer_full),
        .if_req         (if_req),
        .if_addr        (if_addr),
        .if_done        (if_done),
        .if_data        (if_data),
        .ls_req         (ls_req),
        .ls_wr          (ls_wr),
        .ls_size        (ls_size),
        .ls_addr        (ls_addr),
        .ls_wdata       (ls_wdata),
        .ls_done        (ls_done),
        .ls_rdata       (ls_rdata)
    );

    // RAM model: 4 KiB image indexed by the low address bits; I/O writes are not stored.
    initial begin
        logic [7:0] ram [0:4095];
        for (int i = 0; i < 4096; i++) ram[i] = 8'h00;
        ram[12'h100] = 8'h13; ram[12'h101] = 8'h05; ram[12'h102] = 8'h10; ram[12'h103] = 8'h00;
        ram[12'h010] = 8'h78; ram[12'h011] = 8'h56; ram[12'h012] = 8'h34; ram[12'h013] = 8'h12;
        ram[12'hFFE] = 8'hA1; ram[12'hFFF] = 8'hB2; ram[12'h000] = 8'hC3; ram[12'h001] = 8'hD4;
        mem_din = 8'h00;
        forever begin
            @(posedge clk_in);
            if (mem_wr && (mem_a[17:16] != 2'b11)) ram[mem_a[11:0]] = mem_dout;
            mem_din <= ram[mem_a[11:0]];
        end
    end

    always @(negedge clk_in) begin
        if (mem_wr === 1'b1) wr_cnt = wr_cnt + 1;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, n_checks=%0d", n_checks);
        $fatal(1);
    end

    task automatic tick();
        @(posedge clk_in);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h, expected %h", name, got, exp);
        end
    endtask

    // One request from a single requester; lat = ticks from req to done (0 on timeout).
    task automatic run(input logic is_ls, input logic wr, input logic [1:0] size,
                       input logic [31:0] addr, input logic [31:0] wdata,
                       output logic [31:0] rdata, output int lat, output int nwr);
        int w0;
        w0 = wr_cnt;
        lat = 0;
        rdata = 32'h0;
        if (is_ls) begin
            ls_wr = wr; ls_size = size; ls_addr = addr; ls_wdata = wdata; ls_req = 1'b1;
        end else begin
            if_addr = addr; if_req = 1'b1;
        end
        for (int i = 1; i <= 50 && lat == 0; i++) begin
            tick();
            if (is_ls && ls_done) begin lat = i; rdata = ls_rdata; end
            if (!is_ls && if_done) begin lat = i; rdata = if_data; end
        end
        ls_req = 1'b0;
        if_req = 1'b0;
        nwr = wr_cnt - w0;
        tick();
    endtask

    // Simultaneous IF fetch @0x100 and LSU word load @0x10; first: 1 = LSU, 2 = IF.
    task automatic tie(output int first, output logic [31:0] ld, output logic [31:0] fd);
        if_addr = 32'h100;
        ls_wr = 1'b0; ls_size = 2'd2; ls_addr = 32'h10;
        if_req = 1'b1; ls_req = 1'b1;
        first = 0; ld = 32'h0; fd = 32'h0;
        for (int i = 0; i < 60 && (if_req || ls_req); i++) begin
            tick();
            if (ls_done) begin if (first == 0) first = 1; ld = ls_rdata; ls_req = 1'b0; end
            if (if_done) begin if (first == 0) first = 2; fd = if_data; if_req = 1'b0; end
        end
        if_req = 1'b0; ls_req = 1'b0;
        tick();
    endtask

    initial begin
        logic [31:0] rd, ld, fd;
        logic [31:0] seen [$];
        int lat, nwr, w0, dn, bad_a, first, exp_first2;

        rst_in = 1'b0; rdy_in = 1'b1; io_buffer_full = 1'b0;
        if_req = 1'b0; if_addr = 32'h0;
        ls_req = 1'b0; ls_wr = 1'b0; ls_size = 2'd0; ls_addr = 32'h0; ls_wdata = 32'h0;

        //            wr    size   addr           wdata          exp_rdata     lat nwr
        vecs[0] = '{1'b1, 2'd1, 32'h0000_0204, 32'hAABB_CCDD, 32'h0,         3, 2};
        vecs[1] = '{1'b0, 2'd0, 32'h0000_0205, 32'h0,         32'h0000_00CC, 3, 0};
        vecs[2] = '{1'b0, 2'd1, 32'h0000_0204, 32'h0,         32'h0000_CCDD, 4, 0};
        vecs[3] = '{1'b0, 2'd0, 32'h0000_0206, 32'h0,         32'h0000_0000, 3, 0};
        vecs[4] = '{1'b1, 2'd2, 32'h0000_0300, 32'h1122_3344, 32'h0,         5, 4};
        vecs[5] = '{1'b0, 2'd2, 32'h0000_0300, 32'h0,         32'h1122_3344, 6, 0};
        vecs[6] = '{1'b0, 2'd3, 32'h0000_0010, 32'h0,         32'h1234_5678, 6, 0};
        vecs[7] = '{1'b1, 2'd0, 32'h0000_0301, 32'h0000_00EE, 32'h0,         2, 1};
        vecs[8] = '{1'b0, 2'd2, 32'h0000_0300, 32'h0,         32'h1122_EE44, 6, 0};
        vecs[9] = '{1'b0, 2'd2, 32'hFFFF_FFFE, 32'h0,         32'hD4C3_B2A1, 6, 0};

        repeat (2) tick();
        check("rst_mem_a", mem_a, 32'h0);
        check("rst_mem_wr", {31'h0, mem_wr}, 32'h0);
        check("rst_mem_dout", {24'h0, mem_dout}, 32'h0);
        check("rst_dones", {30'h0, if_done, ls_done}, 32'h0);
        check("rst_if_data", if_data, 32'h0);
        check("rst_ls_rdata", ls_rdata, 32'h0);
        rst_in = 1'b1;
        tick();

        run(1'b0, 1'b0, 2'd2, 32'h100, 32'h0, rd, lat, nwr);
        check("fetch_data", rd, 32'h0010_0513);
        check("fetch_lat", lat, 6);
        check("fetch_no_wr", nwr, 0);

        for (int i = 0; i < 10; i++) begin
            run(1'b1, vecs[i].wr, vecs[i].size, vecs[i].addr, vecs[i].wdata, rd, lat, nwr);
            check($sformatf("v%0d_lat", i), lat, vecs[i].exp_lat);
            check($sformatf("v%0d_nwr", i), nwr, vecs[i].exp_nwr);
            if (!vecs[i].wr) check($sformatf("v%0d_rdata", i), rd, vecs[i].exp_rdata);
        end

        // I/O write held off by a full UART buffer.
        io_buffer_full = 1'b1;
        ls_wr = 1'b1; ls_size = 2'd0; ls_addr = 32'h0003_0000; ls_wdata = 32'h0000_0041; ls_req = 1'b1;
        w0 = wr_cnt; bad_a = 0; dn = 0;
        repeat (7) begin
            tick();
            if (mem_a != 32'h0) bad_a++;
            if (ls_done) dn++;
        end
        check("io_hold_wr", wr_cnt - w0, 0);
        check("io_hold_addr", bad_a, 0);
        check("io_hold_done", dn, 0);
        io_buffer_full = 1'b0;
        tick();
        check("io_wr_strobe", {31'h0, mem_wr}, 32'h1);
        check("io_wr_addr", mem_a, 32'h0003_0000);
        check("io_wr_data", {24'h0, mem_dout}, 32'h41);
        check("io_early_done", {31'h0, ls_done}, 32'h0);
        tick();
        check("io_done", {31'h0, ls_done}, 32'h1);
        ls_req = 1'b0;
        tick();
        check("io_one_write", wr_cnt - w0, 1);

        // rdy_in low for three cycles in the middle of a word fetch.
        if_addr = 32'h100; if_req = 1'b1;
        repeat (3) tick();
        rdy_in = 1'b0; dn = 0;
        repeat (3) begin
            tick();
            if (if_done) dn++;
        end
        rdy_in = 1'b1;
        rd = 32'h0; lat = 0;
        for (int i = 1; i <= 30 && lat == 0; i++) begin
            tick();
            if (mem_a != 32'h0 && !mem_wr) seen.push_back(mem_a);
            if (if_done) begin lat = i; rd = if_data; end
        end
        if_req = 1'b0;
        tick();
        check("stall_no_done", dn, 0);
        check("stall_data", rd, 32'h0010_0513);
        check("stall_reissue_cnt", seen.size(), 3);
        check("stall_reissue_first", seen[0], 32'h101);
        check("stall_reissue_last", seen[2], 32'h103);

        // Reset in the middle of a word store.
        ls_wr = 1'b1; ls_size = 2'd2; ls_addr = 32'h400; ls_wdata = 32'hCAFE_F00D; ls_req = 1'b1;
        repeat (2) tick();
        check("abort_pre_wr", {31'h0, mem_wr}, 32'h1);
        rst_in = 1'b0; ls_req = 1'b0;
        tick();
        check("abort_mem_wr", {31'h0, mem_wr}, 32'h0);
        check("abort_mem_a", mem_a, 32'h0);
        rst_in = 1'b1;
        w0 = wr_cnt; dn = 0;
        repeat (6) begin
            tick();
            if (ls_done) dn++;
        end
        check("abort_no_done", dn, 0);
        check("abort_no_wr", wr_cnt - w0, 0);

        // Ties: the first follows reset, the second follows a solo LSU access.
        tie(first, ld, fd);
        check("tie1_first", first, 1);
        check("tie1_ls_data", ld, 32'h1234_5678);
        check("tie1_if_data", fd, 32'h0010_0513);
        run(1'b1, 1'b0, 2'd0, 32'h205, 32'h0, rd, lat, nwr);
        check("solo_ls_data", rd, 32'h0000_00CC);
`ifdef MEM_CTRL_RR_EN
        exp_first2 = 2;
`else
        exp_first2 = 1;
`endif
        tie(first, ld, fd);
        check("tie2_first", first, exp_first2);
        check("tie2_ls_data", ld, 32'h1234_5678);
        check("tie2_if_data", fd, 32'h0010_0513);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
